// File: rtl/mux_rr_n.sv
// N-input round-robin arbitrating mux with a registered valid/ready output stage.
// Define MUX_RR_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux_rr_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel
);

    logic                slot_free;
    logic                grant_valid;
    logic                accept;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    scan_idx;
    logic [SEL_W-1:0]    next_ptr;
    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] eligible;
    logic [WIDTH-1:0]    grant_data;

`ifdef MUX_RR_LOCK_EN
    logic                locked;
    logic [SEL_W-1:0]    lock_ch;

    // While a burst is open only the locked channel may win, even if it idles.
    always_comb begin
        eligible = in_valid;
        if (locked) begin
            eligible          = '0;
            eligible[lock_ch] = in_valid[lock_ch];
        end
    end
`else
    assign eligible = in_valid;
`endif

    assign slot_free = !out_valid || out_ready;

    // Scan from ptr upward, wrapping explicitly so unused indices are never visited.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = ptr;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!grant_valid && eligible[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == SEL_W'(CHANNELS - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    assign accept     = grant_valid && slot_free && !rst;
    assign next_ptr   = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_data = in_data[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = accept && (grant_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef MUX_RR_LOCK_EN
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_last  <= in_last[grant_idx];
            out_sel   <= grant_idx;
            ptr       <= next_ptr;
`ifdef MUX_RR_LOCK_EN
            if (locked) begin
                if (in_last[grant_idx]) begin
                    locked <= 1'b0;
                end
            end else if (!in_last[grant_idx]) begin
                locked  <= 1'b1;
                lock_ch <= grant_idx;
            end
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model.
module tb_mux_rr_n;

    localparam int WIDTH = 4;
    localparam int CH    = 4;
`ifdef MUX_RR_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CH*WIDTH-1:0] in_data = '0;
    logic [CH-1:0]       in_valid = '0;
    logic [CH-1:0]       in_last = '0;
    logic [CH-1:0]       in_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                out_last;
    logic [1:0]          out_sel;

    logic [3*WIDTH-1:0]  d3_in_data = '0;
    logic [2:0]          d3_in_valid = '0;
    logic [2:0]          d3_in_last = 3'b111;
    logic [2:0]          d3_in_ready;
    logic [WIDTH-1:0]    d3_out_data;
    logic                d3_out_valid;
    logic                d3_out_ready = 1'b1;
    logic                d3_out_last;
    logic [1:0]          d3_out_sel;

    int compared = 0;
    int mismatched = 0;

    int          m_ptr = 0;
    bit          m_locked = 0;
    int          m_lock = 0;
    bit          m_valid = 0;
    logic [3:0]  m_data = '0;
    bit          m_last = 0;
    int          m_sel = 0;

    logic [3:0]  rr_data [4] = '{4'h0, 4'hF, 4'hA, 4'h5};

    mux_rr_n #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_sel(out_sel)
    );

    mux_rr_n #(.WIDTH(WIDTH), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_last(d3_in_last), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .out_last(d3_out_last), .out_sel(d3_out_sel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] v, input logic [CH*WIDTH-1:0] d,
                                 input logic [CH-1:0] l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic resetModel();
        m_ptr = 0; m_locked = 0; m_lock = 0;
        m_valid = 0; m_data = '0; m_last = 0; m_sel = 0;
    endtask

    // Compares the DUT against the model for this cycle, then advances the model past the next edge.
    task automatic stepCycle();
        int g;
        int idx;
        bit free;
        logic [CH-1:0] exp_ready;
        #1;
        g = -1;
        for (int k = 0; k < CH; k++) begin
            idx = (m_ptr + k) % CH;
            if (g < 0 && in_valid[idx] && (!m_locked || idx == m_lock)) g = idx;
        end
        free = !m_valid || out_ready;
        exp_ready = '0;
        if (g >= 0 && free && !rst) exp_ready[g] = 1'b1;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("out_data", 32'(out_data), 32'(m_data));
        checkOutput("out_last", 32'(out_last), 32'(m_last));
        checkOutput("out_sel", 32'(out_sel), 32'(m_sel));
        if (!rst) begin
            if (g >= 0 && free) begin
                m_valid = 1;
                m_data  = in_data[g*WIDTH +: WIDTH];
                m_last  = in_last[g];
                m_sel   = g;
                m_ptr   = (g + 1) % CH;
                if (LOCK_EN) begin
                    if (m_locked) begin
                        if (in_last[g]) m_locked = 0;
                    end else if (!in_last[g]) begin
                        m_locked = 1;
                        m_lock   = g;
                    end
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    initial begin
        $display("[TB] start, lock build = %0d", LOCK_EN);

        // Reset held with every channel requesting
        applyStimulus(4'b1111, 16'h5AF0, 4'b1111, 1'b1);
        d3_in_valid = 3'b111;
        stepCycle();
        checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_d3_in_ready", 32'(d3_in_ready), 32'h0);
        d3_in_valid = 3'b000;

        // Round robin with all channels valid; reset released in the first cycle
        for (int k = 0; k < 9; k++) begin
            applyStimulus(4'b1111, 16'h5AF0, 4'b1111, 1'b1);
            if (k == 0) rst = 1'b0;
            stepCycle();
            if (k == 0) checkOutput("first_grant", 32'(in_ready), 32'h1);
            if (k >= 1) begin
                checkOutput("rr_sel", 32'(out_sel), 32'((k - 1) % 4));
                checkOutput("rr_data", 32'(out_data), 32'(rr_data[(k - 1) % 4]));
                checkOutput("rr_no_bubble", 32'(out_valid), 32'h1);
            end
        end

        // Single channel with output stall
        applyStimulus(4'b0000, '0, 4'b1111, 1'b1);
        stepCycle();
        applyStimulus(4'b0100, 16'h0700, 4'b1111, 1'b0);
        stepCycle();
        checkOutput("stall_accept", 32'(in_ready), 32'h4);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0100, 16'h0700, 4'b1111, 1'b0);
            stepCycle();
            checkOutput("stall_ready", 32'(in_ready), 32'h0);
            checkOutput("stall_hold", 32'(out_data), 32'h7);
            checkOutput("stall_valid", 32'(out_valid), 32'h1);
        end
        applyStimulus(4'b0000, 16'h0700, 4'b1111, 1'b1);
        stepCycle();
        checkOutput("stall_drain_hold", 32'(out_data), 32'h7);
        applyStimulus(4'b0000, '0, 4'b1111, 1'b1);
        stepCycle();
        checkOutput("stall_drained", 32'(out_valid), 32'h0);

        // Three-channel pointer wrap after granting the top channel
        applyStimulus(4'b0000, '0, 4'b1111, 1'b1);
        d3_in_valid = 3'b100;
        d3_in_data  = 12'h300;
        stepCycle();
        applyStimulus(4'b0000, '0, 4'b1111, 1'b1);
        stepCycle();
        checkOutput("wrap3_first", 32'(d3_out_sel), 32'h2);
        d3_in_valid = 3'b101;
        d3_in_data  = 12'h309;
        #1;
        checkOutput("wrap3_ready", 32'(d3_in_ready), 32'h1);
        applyStimulus(4'b0000, '0, 4'b1111, 1'b1);
        stepCycle();
        checkOutput("wrap3_sel", 32'(d3_out_sel), 32'h0);
        checkOutput("wrap3_data", 32'(d3_out_data), 32'h9);
        d3_in_valid = 3'b000;

`ifdef MUX_RR_LOCK_EN
        // Burst lock on channel 1 with channel 0 always requesting and a mid-burst gap
        applyStimulus(4'b0001, 16'h0021, 4'b0001, 1'b1);
        stepCycle();
        applyStimulus(4'b0011, 16'h0021, 4'b0000, 1'b1);
        stepCycle();
        checkOutput("lock_b1", 32'(in_ready), 32'h2);
        applyStimulus(4'b0011, 16'h0031, 4'b0000, 1'b1);
        stepCycle();
        checkOutput("lock_b2", 32'(in_ready), 32'h2);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0001, 16'h0001, 4'b0000, 1'b1);
            stepCycle();
            checkOutput("lock_gap", 32'(in_ready), 32'h0);
        end
        applyStimulus(4'b0011, 16'h0041, 4'b0010, 1'b1);
        stepCycle();
        checkOutput("lock_b3", 32'(in_ready), 32'h2);
        applyStimulus(4'b0001, 16'h0001, 4'b0000, 1'b1);
        stepCycle();
        checkOutput("lock_release", 32'(in_ready), 32'h1);
        checkOutput("lock_last_sel", 32'(out_sel), 32'h1);
        checkOutput("lock_last_flag", 32'(out_last), 32'h1);
`endif

        // Asynchronous reset while holding a beat (and a lock on channel 0 when enabled)
        applyStimulus(4'b0000, '0, 4'b0000, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 16'h000C, 4'b0000, 1'b0);
        stepCycle();
        applyStimulus(4'b0001, 16'h000C, 4'b0000, 1'b0);
        stepCycle();
        checkOutput("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
        checkOutput("async_rst_ready", 32'(in_ready), 32'h0);
        resetModel();
        applyStimulus(4'b0110, 16'h0D50, 4'b1111, 1'b1);
        rst = 1'b0;
        stepCycle();
        checkOutput("post_rst_grant", 32'(in_ready), 32'h2);
        applyStimulus(4'b0000, '0, 4'b1111, 1'b1);
        stepCycle();
        checkOutput("post_rst_sel", 32'(out_sel), 32'h1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            applyStimulus(CH'($urandom), (CH*WIDTH)'($urandom), CH'($urandom),
                          ($urandom_range(0, 3) != 0));
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
